// File: rtl/mc14500_program_loader.sv
// mc14500_program_loader: buffers a framed command stream, validates it, then
// replays it into the MC14500B core's program-load port as one burst.
// Frame: LEN, N x (HI, LO), CHK. LEN=0 means 2**ADDR_W commands.
// CHK = XOR of LEN and every HI/LO byte. HI[7:4] must be zero.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   in_data/valid   - frame byte input (transfer on in_valid && in_ready)
//   in_ready        - loader can take a byte this cycle
//   core_rst        - core reset
//   program_write   - core program_write
//   program_cmd     - core program_cmd {opcode[11:8], address[7:0]}
//   busy            - frame reception or streaming in progress
//   done / err      - level status of the last frame (loaded / rejected)
module mc14500_program_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CMD_W  = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             core_rst,
  output logic             program_write,
  output logic [CMD_W-1:0] program_cmd,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned NW    = ADDR_W + 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RX_HI,
    S_RX_LO,
    S_RX_CHK,
    S_PREF,
    S_HDR,
    S_CMD,
    S_TAIL,
    S_END,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state;
  logic [NW-1:0]       n_len;
  logic [NW-1:0]       idx;
  logic [NW-1:0]       cnt;
  logic [7:0]          csum;
  logic                fmt_bad;
  logic [3:0]          hi_nib;
  logic [ADDR_W-1:0]   rd_addr;
  logic [CMD_W-1:0]    rd_data;
  logic [CMD_W-1:0]    ram [DEPTH];

  logic                accept_c;
  logic                ram_we_c;

  assign accept_c = in_valid && in_ready;
  assign ram_we_c = accept_c && (state == S_RX_LO);

  // Command RAM: synchronous write on LO byte, synchronous read every cycle.
  always_ff @(posedge clk) begin
    if (ram_we_c) begin
      ram[idx[ADDR_W-1:0]] <= CMD_W'({hi_nib, in_data});
    end
    rd_data <= ram[rd_addr];
  end

  // Frame reception and replay sequencer; every output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      n_len         <= '0;
      idx           <= '0;
      cnt           <= '0;
      csum          <= '0;
      fmt_bad       <= 1'b0;
      hi_nib        <= '0;
      rd_addr       <= '0;
      in_ready      <= 1'b1;
      core_rst      <= 1'b1;
      program_write <= 1'b0;
      program_cmd   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          // LEN byte: hold the core in reset from here on until the frame resolves.
          if (accept_c) begin
            state    <= S_RX_HI;
            csum     <= in_data;
            fmt_bad  <= 1'b0;
            idx      <= '0;
            n_len    <= (in_data == 8'd0) ? NW'(DEPTH) : NW'(in_data);
            core_rst <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
          end
        end
        S_RX_HI: begin
          if (accept_c) begin
            hi_nib <= in_data[3:0];
            csum   <= csum ^ in_data;
            if (in_data[7:4] != 4'd0) begin
              fmt_bad <= 1'b1;
            end
            state  <= S_RX_LO;
          end
        end
        S_RX_LO: begin
          if (accept_c) begin
            csum <= csum ^ in_data;
            idx  <= idx + NW'(1);
            if ((idx + NW'(1)) == n_len) begin
              state <= S_RX_CHK;
            end else begin
              state <= S_RX_HI;
            end
          end
        end
        S_RX_CHK: begin
          if (accept_c) begin
            if ((in_data == csum) && !fmt_bad) begin
              state    <= S_PREF;
              in_ready <= 1'b0;
              rd_addr  <= '0;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        // One idle slot so RAM[0] is already in rd_data when commands start.
        S_PREF: begin
          state <= S_HDR;
        end
        S_HDR: begin
          core_rst      <= 1'b1;
          program_write <= 1'b1;
          program_cmd   <= '0;
          rd_addr       <= rd_addr + ADDR_W'(1);
          cnt           <= '0;
          state         <= S_CMD;
        end
        // rd_addr runs one ahead of the command being emitted.
        S_CMD: begin
          core_rst      <= 1'b0;
          program_write <= 1'b1;
          program_cmd   <= rd_data;
          rd_addr       <= rd_addr + ADDR_W'(1);
          cnt           <= cnt + NW'(1);
          if (cnt == (n_len - NW'(1))) begin
            state <= S_TAIL;
          end
        end
        S_TAIL: begin
          core_rst      <= 1'b1;
          program_write <= 1'b1;
          program_cmd   <= '0;
          state         <= S_END;
        end
        S_END: begin
          core_rst      <= 1'b0;
          program_write <= 1'b0;
          program_cmd   <= '0;
          done          <= 1'b1;
          busy          <= 1'b0;
          in_ready      <= 1'b1;
          state         <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc14500_program_loader.sv
// Testbench for mc14500_program_loader: frame-level model builds the expected
// write burst; a per-cycle compare process checks the core-side outputs.
module tb_mc14500_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        core_rst;
  logic        program_write;
  logic [11:0] program_cmd;
  logic        busy;
  logic        done;
  logic        err;

  mc14500_program_loader #(.ADDR_W(8), .CMD_W(12)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .core_rst      (core_rst),
    .program_write (program_write),
    .program_cmd   (program_cmd),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  frame_q [$];
  logic [13:0] exp_q   [$];   // {core_rst, program_write, program_cmd}

  int  pw_cnt;
  bit  in_burst;
  bit  lat_arm;
  int  lat_cnt;
  int  lat_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Frame-level model: decode the byte list and build the expected burst.
  task automatic model_frame(output bit ok, output int n);
    logic [7:0] x;
    logic [7:0] hi;
    logic [7:0] lo;
    bit fmt;
    exp_q.delete();
    n  = (frame_q[0] == 8'd0) ? 256 : int'(frame_q[0]);
    ok = (frame_q.size() == 2 * n + 2);
    if (!ok) return;
    x   = frame_q[0];
    fmt = 1'b0;
    for (int i = 0; i < n; i++) begin
      hi = frame_q[1 + 2 * i];
      lo = frame_q[2 + 2 * i];
      x  = x ^ hi ^ lo;
      if (hi[7:4] != 4'd0) fmt = 1'b1;
    end
    ok = !fmt && (x == frame_q[2 * n + 1]);
    if (ok) begin
      exp_q.push_back({1'b1, 1'b1, 12'h000});
      for (int i = 0; i < n; i++) begin
        hi = frame_q[1 + 2 * i];
        lo = frame_q[2 + 2 * i];
        exp_q.push_back({1'b0, 1'b1, hi[3:0], lo});
      end
      exp_q.push_back({1'b1, 1'b1, 12'h000});
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_frame(input bit ok, input int n, input bit gaps, input bit junk);
    int k;
    pw_cnt  = 0;
    lat_cnt = 0;
    lat_val = -1;
    for (int i = 0; i < frame_q.size(); i++) begin
      send_byte(frame_q[i], gaps);
      if (i == 0) begin
        #1;
        chk("len_core_rst", {31'd0, core_rst}, 32'd1);
        chk("len_done_clr", {31'd0, done}, 32'd0);
        chk("len_err_clr",  {31'd0, err},  32'd0);
        chk("len_busy",     {31'd0, busy}, 32'd1);
      end
    end
    if (ok) lat_arm = 1'b1;
    if (junk) begin
      in_data  = 8'hAA;
      in_valid = 1'b1;
    end
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (junk && busy) chk("ready_during_stream", {31'd0, in_ready}, 32'd0);
    end while (!((done || err) && !busy) && k < 600);
    in_valid = 1'b0;
    if (k >= 600) chk("frame_timeout", {31'd0, busy}, 32'd0);
    if (ok) begin
      chk("done",          {31'd0, done},          32'd1);
      chk("err",           {31'd0, err},           32'd0);
      chk("core_released", {31'd0, core_rst},      32'd0);
      chk("pw_after",      {31'd0, program_write}, 32'd0);
      chk("ready_after",   {31'd0, in_ready},      32'd1);
      chk("pw_count",      32'(pw_cnt),            32'(n + 2));
      chk("burst_left",    32'(exp_q.size()),      32'd0);
      chk("latency",       32'(lat_val),           32'd2);
    end else begin
      chk("err",           {31'd0, err},           32'd1);
      chk("done",          {31'd0, done},          32'd0);
      chk("core_held",     {31'd0, core_rst},      32'd1);
      chk("pw_after",      {31'd0, program_write}, 32'd0);
      chk("pw_count",      32'(pw_cnt),            32'd0);
    end
    lat_arm = 1'b0;
  endtask

  task automatic add(input logic [7:0] b);
    frame_q.push_back(b);
  endtask

  task automatic good_frame();
    frame_q.delete();
    add(8'h02); add(8'h06); add(8'hFF); add(8'h0C); add(8'h05); add(8'hF2);
  endtask

  // Per-cycle compare of the core-side outputs against the expected burst.
  always @(negedge clk) begin
    if (rst) begin
      in_burst = 1'b0;
    end else begin
      if (!program_write || core_rst) chk("cmd_zero", {20'd0, program_cmd}, 32'd0);
      if (lat_arm) begin
        if (program_write) begin
          lat_val = lat_cnt;
          lat_arm = 1'b0;
        end else begin
          lat_cnt++;
        end
      end
      if (program_write) begin
        pw_cnt++;
        chk("ready_in_burst", {31'd0, in_ready}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("write_without_frame", {31'd0, program_write}, 32'd0);
        end else begin
          chk("burst", {18'd0, core_rst, program_write, program_cmd}, {18'd0, exp_q.pop_front()});
          in_burst = (exp_q.size() != 0);
        end
      end else if (in_burst) begin
        chk("burst_gap", {31'd0, program_write}, 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int n;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    lat_arm  = 1'b0;
    pw_cnt   = 0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready},      32'd1);
    chk("rst_core_rst", {31'd0, core_rst},      32'd1);
    chk("rst_pw",       {31'd0, program_write}, 32'd0);
    chk("rst_cmd",      {20'd0, program_cmd},   32'd0);
    chk("rst_busy",     {31'd0, busy},          32'd0);
    chk("rst_done",     {31'd0, done},          32'd0);
    chk("rst_err",      {31'd0, err},           32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Good two-command frame, continuous valid.
    good_frame();
    model_frame(ok, n);
    chk("model_good_ok", {31'd0, ok}, 32'd1);
    chk("model_good_len", 32'(exp_q.size()), 32'd4);
    chk("model_cmd0", {18'd0, exp_q[1]}, 32'h16FF);
    chk("model_cmd1", {18'd0, exp_q[2]}, 32'h1C05);
    run_frame(ok, n, 1'b0, 1'b0);
    chk("good_pw_cycles", 32'(pw_cnt), 32'd4);

    // Bad checksum.
    good_frame();
    frame_q[5] = 8'hF3;
    model_frame(ok, n);
    chk("model_badchk_ok", {31'd0, ok}, 32'd0);
    run_frame(ok, n, 1'b0, 1'b0);

    // Format error with a matching checksum: 01^16^22 = 35.
    frame_q.delete();
    add(8'h01); add(8'h16); add(8'h22); add(8'h35);
    model_frame(ok, n);
    chk("model_fmt_ok", {31'd0, ok}, 32'd0);
    run_frame(ok, n, 1'b0, 1'b0);

    // Full depth: XOR of all index bytes and nibbles over 0..255 is zero.
    frame_q.delete();
    add(8'h00);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = 8'(i);
      add({4'h0, v[3:0]});
      add(v);
    end
    add(8'h00);
    model_frame(ok, n);
    chk("model_full_ok", {31'd0, ok}, 32'd1);
    chk("model_full_len", 32'(exp_q.size()), 32'd258);
    run_frame(ok, n, 1'b0, 1'b0);
    chk("full_pw_cycles", 32'(pw_cnt), 32'd258);

    // Backpressure on input, junk held valid during the stream.
    good_frame();
    model_frame(ok, n);
    run_frame(ok, n, 1'b1, 1'b1);
    chk("bp_pw_cycles", 32'(pw_cnt), 32'd4);

    // Reset after the third byte of a frame.
    frame_q.delete();
    send_byte(8'h02, 1'b0);
    send_byte(8'h06, 1'b0);
    send_byte(8'hFF, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_core_rst", {31'd0, core_rst},      32'd1);
    chk("midrst_pw",       {31'd0, program_write}, 32'd0);
    chk("midrst_ready",    {31'd0, in_ready},      32'd1);
    chk("midrst_busy",     {31'd0, busy},          32'd0);
    chk("midrst_done",     {31'd0, done},          32'd0);
    chk("midrst_err",      {31'd0, err},           32'd0);
    @(negedge clk);
    rst = 1'b0;
    good_frame();
    model_frame(ok, n);
    run_frame(ok, n, 1'b0, 1'b0);

    // Reload from DONE: 01^03^21 = 23, command 0x321.
    frame_q.delete();
    add(8'h01); add(8'h03); add(8'h21); add(8'h23);
    model_frame(ok, n);
    chk("model_reload_cmd", {18'd0, exp_q[1]}, 32'h1321);
    run_frame(ok, n, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
